// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and GF(2^8) helper
package aes_pkg;
    localparam int AES_NR    = 10;
    localparam int BYTE0_LSB = 120;
    typedef enum logic [2:0] {S_IDLE, S_ARK0, S_SB_START, S_SB_WAIT, S_DONE} state_e;
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_round_ctrl_mix_columns.sv
// mix_columns: combinational AES MixColumns over four 32-bit columns
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[BYTE0_LSB - 32*c      +: 8];
        assign a1 = data_i[BYTE0_LSB - 32*c - 8  +: 8];
        assign a2 = data_i[BYTE0_LSB - 32*c - 16 +: 8];
        assign a3 = data_i[BYTE0_LSB - 32*c - 24 +: 8];
        assign data_o[BYTE0_LSB - 32*c      +: 8] = gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3;
        assign data_o[BYTE0_LSB - 32*c - 8  +: 8] = a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3;
        assign data_o[BYTE0_LSB - 32*c - 16 +: 8] = a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3;
        assign data_o[BYTE0_LSB - 32*c - 24 +: 8] = gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3);
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer around a byte-serial SubBytes/ShiftRows unit
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR         = AES_NR,
    parameter int SB_TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [127:0] data_in,
    input  logic [127:0] rk_in,
    output logic [3:0]   rk_addr_out,
    output logic         sb_start_out,
    output logic [127:0] sb_data_out,
    input  logic [127:0] sb_data_in,
    input  logic         sb_ready_in,
    output logic [127:0] data_out,
    output logic         done_out,
    output logic         busy_out,
    output logic         err_out
);
    localparam int WDW = $clog2(SB_TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [127:0]   sreg_q, sreg_d, dout_q, dout_d, mix;
    logic           err_q, err_d;

    mix_columns u_mix (
        .data_i (sb_data_in),
        .data_o (mix)
    );

    // Next state: accept, initial key add, per-round SubBytes handshake with watchdog, final round
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        wd_d    = wd_q;
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start_in) begin
                sreg_d  = data_in;
                round_d = '0;
                state_d = S_ARK0;
            end
            S_ARK0: begin
                sreg_d  = sreg_q ^ rk_in;
                round_d = 4'd1;
                state_d = S_SB_START;
            end
            S_SB_START: begin
                wd_d    = '0;
                state_d = S_SB_WAIT;
            end
            S_SB_WAIT: if (sb_ready_in) begin
                if (round_q < 4'(NR)) begin
                    sreg_d  = mix ^ rk_in;
                    round_d = round_q + 4'd1;
                    state_d = S_SB_START;
                end else begin
                    dout_d  = sb_data_in ^ rk_in;
                    state_d = S_DONE;
                end
            end else begin
                wd_d = wd_q + 1'b1;
                if (wd_d == WDW'(SB_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, round, watchdog and data registers; reset aborts any encryption in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            wd_q    <= '0;
            sreg_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wd_q    <= wd_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign rk_addr_out  = round_q;
    assign sb_start_out = state_q == S_SB_START;
    assign sb_data_out  = sreg_q;
    assign data_out     = dout_q;
    assign done_out     = state_q == S_DONE;
    assign busy_out     = state_q != S_IDLE;
    assign err_out      = err_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for the AES round sequencer with a behavioural SubBytes/ShiftRows unit
module tb_aes_round_ctrl;
    localparam int LS  = 17;
    localparam int NR  = 10;
    localparam int TMO = 31;
    // Edges after the accept edge at which the pulse is sampled (done in cycle 182, err in cycle 34)
    localparam int DONE_OFS = 1 + NR * (1 + LS);
    localparam int ERR_OFS  = 2 + TMO;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        bit           is_err;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b0, start_in = 1'b0, sb_ready_in = 1'b0;
    logic [127:0] data_in = '0, sb_data_in = '0, rk_in, sb_data_out, data_out;
    logic [3:0]   rk_addr_out;
    logic         sb_start_out, done_out, busy_out, err_out;

    logic [127:0] rkeys [16];
    logic [127:0] sb_lat = '0;
    int           sb_cnt = 0;
    bit           sb_stuck = 0, stray_idle = 0, stray_start = 0;
    int           cyc = 0, checks = 0, errors = 0, a = 0, n = 0;
    exp_t         sb_q [$];
    exp_t         mon_e;
    logic         done_prev = 1'b0;

    logic [0:2047] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic [0:79] rcon_bits = 80'h01020408102040801b36;

    aes_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .data_in      (data_in),
        .rk_in        (rk_in),
        .rk_addr_out  (rk_addr_out),
        .sb_start_out (sb_start_out),
        .sb_data_out  (sb_data_out),
        .sb_data_in   (sb_data_in),
        .sb_ready_in  (sb_ready_in),
        .data_out     (data_out),
        .done_out     (done_out),
        .busy_out     (busy_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rk_in = rkeys[rk_addr_out];

    function automatic logic [7:0] sb(input logic [7:0] b);
        return sbox_bits[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] sbsr(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = sb(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        return o;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon_bits[(i/4 - 1)*8 +: 8], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rkeys[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timed_out(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data_out"}, data_out, '0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_err"}, err_out, 0);
        chk({tag, "_sb_start"}, sb_start_out, 0);
        chk({tag, "_rk_addr"}, rk_addr_out, 0);
        chk({tag, "_sb_data"}, sb_data_out, '0);
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (busy_out && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (busy_out) timed_out("wait_idle");
    endtask

    task automatic accept(input logic [127:0] pt, input bit hold, output int acc);
        @(negedge clk);
        data_in  = pt;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) start_in = 1'b0;
    endtask

    // Behavioural SubBytes+ShiftRows unit: ready LS cycles after the start pulse, plus injected stray pulses
    initial begin
        forever begin
            @(negedge clk);
            sb_ready_in = 1'b0;
            if (sb_cnt > 0) begin
                sb_cnt--;
                if (sb_cnt == 0) begin
                    sb_ready_in = 1'b1;
                    sb_data_in  = sbsr(sb_lat);
                end
            end
            if (sb_start_out && !sb_stuck) begin
                sb_lat = sb_data_out;
                sb_cnt = LS;
            end
            if ((stray_start && sb_start_out) || (stray_idle && !busy_out)) begin
                sb_ready_in = 1'b1;
                sb_data_in  = '1;
                stray_start = 0;
                stray_idle  = 0;
            end
        end
    end

    // Monitor: every done/err pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (done_out) chk("done_single_pulse", done_prev, 0);
        if (done_out || err_out) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: done=%b err=%b data_out=%h at cycle %0d, none expected",
                         done_out, err_out, data_out, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_is_err", err_out, mon_e.is_err);
                chk("data_out", data_out, mon_e.data);
                chk("pulse_cycle", cyc, mon_e.cyc);
                if (err_out) chk("busy_at_err", busy_out, 0);
            end
        end
        done_prev <= done_out;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        expand(KEY_B);
        stray_start = 1;
        accept(PT_B, 0, a);
        sb_q.push_back('{1'b0, CT_B, a + DONE_OFS});
        wait_idle(400);

        @(negedge clk);
        #2 stray_idle = 1;
        repeat (4) @(negedge clk);
        chk("idle_stray_busy", busy_out, 0);
        chk("idle_stray_data", data_out, CT_B);
        chk("idle_stray_rk", rk_addr_out, 4'd10);

        expand(KEY_C);
        accept(PT_C, 1, a);
        sb_q.push_back('{1'b0, CT_C, a + DONE_OFS});
        chk("rk_addr_ark0", rk_addr_out, 0);
        for (int r = 1; r <= NR; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!sb_start_out && n < 40);
            if (sb_start_out) chk($sformatf("rk_addr_round%0d", r), rk_addr_out, r);
            else timed_out("sb_start");
        end
        n = 0;
        while (!done_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done_out) timed_out("done_c1");
        @(negedge clk);
        chk("b2b_idle_busy", busy_out, 0);
        @(posedge clk);
        #1;
        chk("b2b_accept_busy", busy_out, 1);
        chk("b2b_accept_rk", rk_addr_out, 0);
        sb_q.push_back('{1'b0, CT_C, a + DONE_OFS + 2 + DONE_OFS});
        start_in = 1'b0;
        wait_idle(400);

        sb_stuck = 1;
        accept(PT_B, 0, a);
        sb_q.push_back('{1'b1, CT_C, a + ERR_OFS});
        wait_idle(100);
        repeat (3) @(negedge clk);
        chk("err_data_kept", data_out, CT_C);
        sb_stuck = 0;

        expand(KEY_B);
        accept(PT_B, 0, a);
        n = 0;
        while (rk_addr_out != 4'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rk_addr_out != 4'd5) timed_out("round5");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset("midrun_reset");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        accept(PT_B, 0, a);
        sb_q.push_back('{1'b0, CT_B, a + DONE_OFS});
        wait_idle(400);
        repeat (3) @(negedge clk);
        chk("queue_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 encryption datapath. It accepts a 128-bit plaintext and sequences the initial AddRoundKey and ten rounds through the existing byte-serial SubBytes/ShiftRows unit, using a start/ready handshake. MixColumns and AddRoundKey are applied locally between SubBytes passes. The block owns the round counter and the round-key index, and delivers the ciphertext with a one-cycle done pulse.

## Interface
- NR, 10: number of rounds; the final round omits MixColumns.
- SB_TIMEOUT, 31: maximum cycles spent in SB_WAIT before abort.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- start_in  in  1: request encryption of data_in; sampled only in IDLE.
- data_in  in  128: plaintext; byte 0 = [127:120]; sampled on the accept edge.
- rk_in  in  128: round key selected by rk_addr_out; valid in the same cycle (combinational read).
- rk_addr_out  out  4: round-key index, equal to the current round counter.
- sb_start_out  out  1: one-cycle start pulse to the SubBytes unit.
- sb_data_out  out  128: state handed to the SubBytes unit; held stable from SB_START until the ready cycle.
- sb_data_in  in  128: SubBytes+ShiftRows result; valid when sb_ready_in=1.
- sb_ready_in  in  1: one-cycle completion pulse from the SubBytes unit.
- data_out  out  128: ciphertext register.
- done_out  out  1: one-cycle pulse; data_out is valid from this cycle onward.
- busy_out  out  1: high from accept until done or abort.
- err_out  out  1: one-cycle pulse on SubBytes timeout.

## Operation
- States: IDLE, ARK0, SB_START, SB_WAIT, DONE.
- IDLE:
  - If start_in=1: capture data_in into state_reg, set round=0, go to ARK0.
  - Otherwise start_in is ignored.
- ARK0:
  - state_reg <= state_reg ^ rk_in, with rk_addr_out=0.
  - round <= 1; go to SB_START.
- SB_START:
  - sb_start_out=1; watchdog cleared; go to SB_WAIT.
- SB_WAIT, when sb_ready_in=1:
  - If round<NR: state_reg <= mix_columns(sb_data_in) ^ rk_in; round++; go to SB_START.
  - If round==NR: data_out <= sb_data_in ^ rk_in; go to DONE.
- SB_WAIT, when sb_ready_in=0:
  - Watchdog increments.
  - On reaching SB_TIMEOUT: pulse err_out, go to IDLE. data_out is unchanged; done_out is not asserted.
- DONE: done_out=1; go to IDLE.
- sb_data_out = state_reg at all times.
- rk_addr_out = round at all times.
- start_in while busy: ignored, never queued.
- sb_ready_in outside SB_WAIT: ignored.
- All XORs are bitwise over 128 bits. mix_columns operates per 32-bit column in GF(2^8) with polynomial 0x11B.

## Timing
- Reset values: state=IDLE, round=0, state_reg=0, data_out=0, done_out=0, busy_out=0, err_out=0, sb_start_out=0, rk_addr_out=0.
- Reset asserted mid-encryption aborts immediately. No done_out or err_out is produced; the next start is accepted normally.
- Accept edge = cycle 0.
  - ARK0 in cycle 1.
  - First SB_START in cycle 2.
- Each round takes 1 + Ls cycles, where Ls = cycles from sb_start_out to sb_ready_in. Ls is 17 for the current SubBytes unit.
- Total latency: done_out in cycle 2 + NR*(1+Ls), which is 182 for NR=10, Ls=17.
- Back-to-back: start_in can be accepted in the cycle after DONE.
- busy_out is combinational: state != IDLE.
- done_out and err_out are registered-state decodes: high exactly one cycle.

## Structure
- Shared package aes_pkg contains:
  - State enum.
  - AES_NR=10.
  - Byte-lane order constant (byte 0 = MSB).
  - gf_xtime function.
- Sub-module mix_columns: combinational, 128-bit in and out, four column instances of the xtime-based mix.
- The controller holds the FSM, round counter, watchdog, state_reg and data_out.

## Test plan
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, real SubBytes unit -> data_out=3925841d02dc09fbdc118597196a0b32, done_out in cycle 182, single pulse.
- FIPS-197 App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102…0f -> 69c4e0d86a7b0430d8cdb78070b4c55a; rk_addr_out steps 0,1,…,10.
- start_in held high throughout encryption -> exactly one accept and one done_out; a second encryption starts in the cycle after DONE.
- SubBytes stub never asserts ready -> err_out pulses after 31 SB_WAIT cycles, busy_out falls, data_out is unchanged.
- rst pulled low in round 5 -> all outputs are at reset values on the same edge; a following App. B run still gives the correct ciphertext.
- Stray sb_ready_in pulse in IDLE and in SB_START -> no state change and no data_out update.
